sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO and the successor to the team's fixed 8-bit/64-entry buffer.
- Adds configurable width and depth, exact full/empty flags, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 64, number of entries; power of two, >=4.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (FWFT=1: acknowledge/pop of the head word).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH; ADDR_W = clog2(DEPTH).
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, sync deassert at the next edge):
  - count=0, empty=1, almost_empty=1, full=0, almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Read and write pointers = 0.
  - Memory contents are not reset.
  - An assertion mid-operation discards all stored words immediately.
- Accept rules:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Both use the registered flags from the current cycle.
- Write on full: no write, no pointer move. This holds even when a read is accepted in the same cycle; there is no write-through on full.
- Read on empty: no read. This holds even when a write is accepted in the same cycle; there is no read-through on empty.
- Pointers:
  - ADDR_W bits wide; wrap naturally from DEPTH-1 to 0.
  - wr_ptr increments on wr_acc; rd_ptr increments on rd_acc.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags:
  - All flags are registered and computed from next-count, so they change in the same cycle as count.
  - No combinational path from inputs to flags.
- Errors:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both remain set until clr_err or rst.
  - If clr_err and a new error event occur in the same cycle, set wins.
- FWFT=0:
  - rd_data is registered; it is loaded with mem[rd_ptr] on the edge where rd_acc is true.
  - rd_valid is high for exactly the following cycle.
  - Otherwise rd_data holds its value and rd_valid=0.
  - Read latency is 1 clock.
- FWFT=1:
  - rd_data = mem[rd_ptr] whenever ~empty; rd_valid = ~empty.
  - rd_en pops the head word; the next word appears the cycle after the pop.
  - Write-to-visible latency: a word written into an empty FIFO appears on rd_data with rd_valid=1 one cycle after the write edge.
- Width rule: count is ADDR_W+1 bits so DEPTH is representable; there is no silent truncation.

Decomposition:
- Package fifo_pkg:
  - Function clog2.
  - Derived constant ADDR_W.
  - Shared FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1), reused by future async FIFOs.
- Sub-module fifo_ram:
  - Simple dual-port array, DATA_W x DEPTH.
  - Synchronous write; read port is asynchronous, so the top level can register it (STD) or pass it through (FWFT).
- Top level holds pointers, count, flags, error logic and the read-data register.

Test Plan (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Fill: write 0x01..0x08 on consecutive cycles.
  - count steps 1..8; almost_empty clears when count=3; almost_full sets when count=6; full=1 after the 8th write.
  - A 9th write of 0xFF sets overflow, and count stays 8.
- Drain (FWFT=0): rd_en for 8 cycles.
  - rd_data = 0x01..0x08, each one cycle after its rd_en, with rd_valid pulsing.
  - empty=1 after the 8th read.
  - A 9th rd_en sets underflow, and rd_data holds 0x08.
- Simultaneous: with count=4, assert wr_en and rd_en for 10 cycles.
  - count stays 4 and the pointers wrap past 7.
  - Data order is preserved across the wrap.
- Boundaries:
  - Full with wr_en & rd_en: count becomes 7 and the write is dropped (overflow=1).
  - Empty with both: count becomes 1, no rd_valid (underflow=1).
- FWFT=1: write 0xA5 to an empty FIFO.
  - Next cycle rd_valid=1 and rd_data=0xA5 with no rd_en.
  - Pulse rd_en: empty=1 on the following cycle.
- Reset mid-stream: assert rst asynchronously (between edges) with count=5.
  - All outputs return to their reset values immediately.
  - clr_err clears sticky flags only when no new error is present in the same cycle.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// fifo_pkg: definitions shared by the synchronous FIFO and its future async
// siblings.
//   clog2()        : ceiling log2, used to size pointers and the occupancy count
//   ADDR_W         : pointer width for the default depth
//   FIFO_STD/FWFT  : read-mode selectors for the FWFT parameter
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned DEFAULT_DEPTH = 64;
    localparam int unsigned ADDR_W        = clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle of the synchronous FIFO.
//   master : drives wr_en, wr_data, rd_en, clr_err; observes data and flags
//   slave  : the FIFO side (the mirror image of master)
// count is clog2(DEPTH)+1 bits wide, so DEPTH itself is representable.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64
);
    localparam int unsigned AW = clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// fifo_ram: simple dual-port storage, DATA_W x DEPTH.
//   clk     : write clock
//   i_we    : write enable, i_waddr / i_wdata : write port
//   i_raddr : read address, o_rdata : asynchronous read data
// The contents are never reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [clog2(DEPTH)-1:0]    i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [clog2(DEPTH)-1:0]    i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of sync_fifo_param_if (write/read requests, data,
//              occupancy count, full/empty/almost flags, sticky error flags)
// Flags are registered from the next-cycle count, so they move together with
// count. FWFT selects a registered read (1-cycle latency) or fall-through.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = FIFO_STD
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);

    localparam int unsigned AW       = clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AW:0]       w_cnt_nxt;
    logic [DATA_W-1:0] w_ram_rd;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_unf;

    // Accepts use the registered flags: no write-through on full and no
    // read-through on empty.
    assign w_wr_acc = bus.wr_en & ~r_full;
    assign w_rd_acc = bus.rd_en & ~r_empty;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_count + CNT_ONE;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNT_FULL);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= CNT_AF);
            r_ae    <= (w_cnt_nxt <= CNT_AE);
            // A new error event in the same cycle as clr_err keeps the flag set.
            r_ovf   <= (r_ovf & ~bus.clr_err) | (bus.wr_en & r_full);
            r_unf   <= (r_unf & ~bus.clr_err) | (bus.rd_en & r_empty);
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rd)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; zero while empty so reset and
            // idle outputs stay deterministic.
            assign bus.rd_data  = r_empty ? '0 : w_ram_rd;
            assign bus.rd_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= w_ram_rd;
                    end
                end
            end

            assign bus.rd_data  = r_rd_data;
            assign bus.rd_valid = r_rd_valid;
        end
    endgenerate

    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;

endmodule
